// File: rtl/sw_btn_conditioner_pkg.sv
// Shared constants and types for the ALU demo input front-end.
// Describes how the 16 board switches split into operand A, operand B and
// the op-select field, and how the 17 debounce cells are indexed.
package alu_io_pkg;

  // Switch field layout on the board
  localparam int N_SW    = 16;
  localparam int A_LSB   = 0;
  localparam int B_LSB   = 8;
  localparam int SEL_LSB = 13;
  localparam int A_W     = 8;
  localparam int B_W     = 5;
  localparam int SEL_W   = 3;

  // One debounce cell per switch plus one for the centre button,
  // which sits just above the switches in the cell vector.
  localparam int N_CELLS = N_SW + 1;
  localparam int BTN_IDX = N_SW;

  // Operand bundle handed to the ALU top
  typedef struct packed {
    logic [2:0] sel;
    logic [4:0] b;
    logic [7:0] a;
  } operand_t;

  // Slice the debounced switch word into its operand fields
  function automatic operand_t split_switches(input logic [N_SW-1:0] sw);
    operand_t op;
    op.a   = sw[A_LSB   +: A_W];
    op.b   = sw[B_LSB   +: B_W];
    op.sel = sw[SEL_LSB +: SEL_W];
    return op;
  endfunction

endpackage

// File: rtl/sw_btn_conditioner_if.sv
// Bundle between the raw board inputs and the conditioned ALU-side outputs.
// master: board/stimulus side (drives raw inputs, observes results).
// slave : the conditioner itself (consumes raw inputs, drives results).
interface sw_btn_conditioner_if;
  import alu_io_pkg::*;

  logic [N_SW-1:0]  sw_raw;
  logic             btn_raw;
  logic [A_W-1:0]   sw_a;
  logic [B_W-1:0]   sw_b;
  logic [SEL_W-1:0] sel;
  logic             btn_level;
  logic             btn_rise;
  logic             btn_fall;
  logic             stable;

  modport master (
    output sw_raw, btn_raw,
    input  sw_a, sw_b, sel, btn_level, btn_rise, btn_fall, stable
  );

  modport slave (
    input  sw_raw, btn_raw,
    output sw_a, sw_b, sel, btn_level, btn_rise, btn_fall, stable
  );

endinterface

// File: rtl/sw_btn_conditioner_debounce_cell.sv
// Single-bit synchroniser + debouncer.
// The raw input passes through SYNC_STAGES flops; the synchronised level s
// must differ from the committed level q for DB_CYCLES consecutive clocks
// before q follows it. Any return to s==q restarts the count, so shorter
// pulses are rejected. o_pending flags a transition still being counted.
module debounce_cell #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_q,
  output logic o_pending
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  logic                   r_q;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_q_next;
  logic [CNT_W-1:0]       w_cnt_next;

  // Shift the asynchronous input through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Debounce decision: hold, count towards commit, or commit
  always_comb begin
    w_q_next   = r_q;
    w_cnt_next = '0;
    if (w_s != r_q) begin
      if (r_cnt == CNT_LAST) begin
        // Level persisted long enough: accept it; counter never wraps
        w_q_next   = w_s;
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + CNT_ONE;
      end
    end
  end

  // Committed level and persistence counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_q   <= w_q_next;
      r_cnt <= w_cnt_next;
    end
  end

  assign o_q       = r_q;
  assign o_pending = (r_cnt != '0);

endmodule

// File: rtl/sw_btn_conditioner.sv
// Input front-end of the ALU/prefix-adder demo.
// Debounces 16 switches and the centre button (17 independent cells),
// splits the switches into operand A / operand B / op-select, and produces
// the clean button level (adder Cin) with one-cycle press/release pulses.
// Build option OPERAND_HOLD_EN: when defined, sw_a/sw_b/sel are captured
// from the debounced switches on each button press and held between
// presses; when undefined they follow the debounced switches directly.
module sw_btn_conditioner
  import alu_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 250000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sw_btn_conditioner_if.slave  bus
);

  logic [N_CELLS-1:0] w_raw;
  logic [N_CELLS-1:0] w_q;
  logic [N_CELLS-1:0] w_pending;
  logic               w_btn_q;
  logic               r_btn_d;
  logic               w_btn_rise;
  logic               w_btn_fall;
  operand_t           w_operand_live;
  operand_t           w_operand;

  // Button occupies the top cell, switches the lower N_SW cells
  assign w_raw = {bus.btn_raw, bus.sw_raw};

  genvar gi;
  generate
    for (gi = 0; gi < N_CELLS; gi++) begin : g_cell
      debounce_cell #(
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
      ) u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_raw     (w_raw[gi]),
        .o_q       (w_q[gi]),
        .o_pending (w_pending[gi])
      );
    end
  endgenerate

  assign w_btn_q = w_q[BTN_IDX];

  // One-cycle delayed button level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_d <= 1'b0;
    end else begin
      r_btn_d <= w_btn_q;
    end
  end

  // Pulses coincide with the first cycle of the new debounced level
  assign w_btn_rise = w_btn_q & ~r_btn_d;
  assign w_btn_fall = ~w_btn_q & r_btn_d;

  assign w_operand_live = split_switches(w_q[N_SW-1:0]);

`ifdef OPERAND_HOLD_EN
  operand_t r_operand;

  // Capture operands on a button press; ignore switch moves in between
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_operand <= '0;
    end else if (w_btn_rise) begin
      r_operand <= w_operand_live;
    end
  end

  assign w_operand = r_operand;
`else
  assign w_operand = w_operand_live;
`endif

  assign bus.sw_a      = w_operand.a;
  assign bus.sw_b      = w_operand.b;
  assign bus.sel       = w_operand.sel;
  assign bus.btn_level = w_btn_q;
  assign bus.btn_rise  = w_btn_rise;
  assign bus.btn_fall  = w_btn_fall;
  // Settled only when no cell is counting towards a commit
  assign bus.stable    = ~|w_pending;

endmodule

// File: tb/tb_sw_btn_conditioner.sv
// Directed bench for sw_btn_conditioner with DB_CYCLES=4, SYNC_STAGES=2.
// Raw edge to committed level is 6 clocks (2 sync + 4 debounce).
// Inputs change and outputs are sampled 1 ns after the rising edge.
`timescale 1ns/1ps
module tb_sw_btn_conditioner;
  import alu_io_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_rise  = 0;
  int   n_fall  = 0;
  int   rise0;
  int   fall0;

  sw_btn_conditioner_if bus();

  sw_btn_conditioner #(
    .SYNC_STAGES (2),
    .DB_CYCLES   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.btn_rise) n_rise++;
    if (bus.btn_fall) n_fall++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // ---- 1: reset with everything pressed, then release ----
    rst_n       = 1'b0;
    bus.sw_raw  = 16'hFFFF;
    bus.btn_raw = 1'b1;
    step(3);
    check("t1_rst_sw_a",   32'(bus.sw_a),      'h0);
    check("t1_rst_sw_b",   32'(bus.sw_b),      'h0);
    check("t1_rst_sel",    32'(bus.sel),       'h0);
    check("t1_rst_level",  32'(bus.btn_level), 'h0);
    check("t1_rst_rise",   32'(bus.btn_rise),  'h0);
    check("t1_rst_fall",   32'(bus.btn_fall),  'h0);
    check("t1_rst_stable", 32'(bus.stable),    'h1);
    rise0 = n_rise;
    rst_n = 1'b1;
    step(5);
    check("t1_e5_level",  32'(bus.btn_level), 'h0);
    check("t1_e5_stable", 32'(bus.stable),    'h0);
    check("t1_e5_sw_a",   32'(bus.sw_a),      'h0);
    step(1);
    check("t1_e6_level", 32'(bus.btn_level), 'h1);
    check("t1_e6_rise",  32'(bus.btn_rise),  'h1);
`ifndef OPERAND_HOLD_EN
    check("t1_e6_sw_a", 32'(bus.sw_a), 'hFF);
    check("t1_e6_sw_b", 32'(bus.sw_b), 'h1F);
    check("t1_e6_sel",  32'(bus.sel),  'h7);
`else
    check("t1_e6_hold_sw_a", 32'(bus.sw_a), 'h0);
`endif
    step(1);
    check("t1_e7_rise",   32'(bus.btn_rise), 'h0);
    check("t1_e7_sw_a",   32'(bus.sw_a),     'hFF);
    check("t1_e7_sw_b",   32'(bus.sw_b),     'h1F);
    check("t1_e7_sel",    32'(bus.sel),      'h7);
    check("t1_e7_stable", 32'(bus.stable),   'h1);
    check("t1_rise_cnt",  32'(n_rise - rise0), 'h1);

    // ---- 2: field mapping, button held ----
    bus.sw_raw = 16'b101_10011_01011010;
    step(3);
    check("t2_pending_stable", 32'(bus.stable), 'h0);
    step(3);
    check("t2_stable", 32'(bus.stable), 'h1);
`ifndef OPERAND_HOLD_EN
    check("t2_sw_a", 32'(bus.sw_a), 'h5A);
    check("t2_sw_b", 32'(bus.sw_b), 'h13);
    check("t2_sel",  32'(bus.sel),  'h5);
`else
    check("t2_hold_sw_a", 32'(bus.sw_a), 'hFF);
    check("t2_hold_sel",  32'(bus.sel),  'h7);
`endif

    // ---- 3: release, then a 3-clock glitch ----
    fall0 = n_fall;
    bus.btn_raw = 1'b0;
    step(6);
    check("t3_rel_level", 32'(bus.btn_level), 'h0);
    check("t3_rel_fall",  32'(bus.btn_fall),  'h1);
    step(1);
    check("t3_fall_cnt", 32'(n_fall - fall0), 'h1);
    rise0 = n_rise;
    bus.btn_raw = 1'b1;
    step(3);
    check("t3_glitch_stable", 32'(bus.stable), 'h0);
    bus.btn_raw = 1'b0;
    step(5);
    check("t3_level",    32'(bus.btn_level), 'h0);
    check("t3_stable",   32'(bus.stable),    'h1);
    check("t3_rise_cnt", 32'(n_rise - rise0), 'h0);

    // ---- 4: bounce 1,0,1,0 then steady 1 ----
    rise0 = n_rise;
    for (int i = 0; i < 4; i++) begin
      bus.btn_raw = ((i % 2) == 0);
      step(1);
    end
    bus.btn_raw = 1'b1;
    step(5);
    check("t4_e9_level", 32'(bus.btn_level), 'h0);
    step(1);
    check("t4_e10_level", 32'(bus.btn_level), 'h1);
    check("t4_e10_rise",  32'(bus.btn_rise),  'h1);
    step(1);
    check("t4_rise_cnt", 32'(n_rise - rise0), 'h1);
`ifdef OPERAND_HOLD_EN
    check("t4_hold_sw_a", 32'(bus.sw_a), 'h5A);
    check("t4_hold_sw_b", 32'(bus.sw_b), 'h13);
    check("t4_hold_sel",  32'(bus.sel),  'h5);
`endif
    fall0 = n_fall;
    bus.btn_raw = 1'b0;
    step(6);
    check("t4_rel_fall", 32'(bus.btn_fall), 'h1);
    step(1);
    check("t4_fall_cnt", 32'(n_fall - fall0), 'h1);

    // ---- 5: reset mid-count ----
    rise0 = n_rise;
    bus.btn_raw = 1'b1;
    step(4);
    check("t5_mid_stable", 32'(bus.stable), 'h0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_stable", 32'(bus.stable),    'h1);
    check("t5_rst_level",  32'(bus.btn_level), 'h0);
    check("t5_rst_sw_a",   32'(bus.sw_a),      'h0);
    bus.btn_raw = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(8);
    check("t5_level",    32'(bus.btn_level), 'h0);
    check("t5_rise_cnt", 32'(n_rise - rise0), 'h0);
`ifndef OPERAND_HOLD_EN
    check("t5_sw_a", 32'(bus.sw_a), 'h5A);
`else
    check("t5_hold_sw_a", 32'(bus.sw_a), 'h0);
`endif
    bus.btn_raw = 1'b1;
    step(6);
    check("t5_press_rise", 32'(bus.btn_rise), 'h1);
    step(1);
    check("t5_press_cnt", 32'(n_rise - rise0), 'h1);
    check("t5_press_sw_a", 32'(bus.sw_a), 'h5A);

`ifdef OPERAND_HOLD_EN
    // ---- 6: operands held until the next press ----
    bus.sw_raw = 16'h1234;
    step(8);
    check("t6_moved_sw_a", 32'(bus.sw_a), 'h5A);
    check("t6_moved_sw_b", 32'(bus.sw_b), 'h13);
    check("t6_moved_sel",  32'(bus.sel),  'h5);
    bus.btn_raw = 1'b0;
    step(7);
    bus.btn_raw = 1'b1;
    step(6);
    check("t6_rise",     32'(bus.btn_rise), 'h1);
    check("t6_pre_sw_a", 32'(bus.sw_a),     'h5A);
    step(1);
    check("t6_sw_a", 32'(bus.sw_a), 'h34);
    check("t6_sw_b", 32'(bus.sw_b), 'h12);
    check("t6_sel",  32'(bus.sel),  'h0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
